pong_game_ctrl: RTL and testbench

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_pkg.sv | 44 ++++
 rtl/pong_game_ctrl_if.sv | 23 ++
 rtl/button_debouncer.sv | 45 ++++
 rtl/pong_game_ctrl_fsm.sv | 109 ++++++++++
 rtl/pong_game_ctrl.sv | 59 +++++
 tb/tb_pong_game_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/pong_pkg.sv
// Shared types, defaults and BCD helpers for the pong game controller.
package pong_pkg;

  localparam int DEF_DEB_CYCLES  = 500000;
  localparam int DEF_START_LIVES = 3;
  localparam int DEF_MISS_FRAMES = 60;
  localparam int BCD_W           = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_MISS_WAIT = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } score_t;

  // Two-digit BCD increment that sticks at 99.
  function automatic score_t bcd_inc(input score_t s);
    score_t r;
    r = s;
    if (s.tens == 4'd9 && s.units == 4'd9) begin
      r = s;
    end else if (s.units == 4'd9) begin
      r.units = 4'd0;
      r.tens  = s.tens + 4'd1;
    end else begin
      r.units = s.units + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [1:0] speed_of(input bcd_t tens);
    if (tens >= 4'd3) return 2'd3;
    return tens[1:0];
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Bundle between the game controller and the ball datapath / VGA timing.
interface pong_game_ctrl_if;
  logic       frame_tick;
  logic       hit;
  logic       miss;
  logic       ball_run;
  logic       ball_reset;
  logic [7:0] score;
  logic [1:0] lives;
  logic [1:0] speed;
  logic [2:0] state;
  logic       led;

  modport master (
    output frame_tick, hit, miss,
    input  ball_run, ball_reset, score, lives, speed, state, led
  );

  modport slave (
    input  frame_tick, hit, miss,
    output ball_run, ball_reset, score, lives, speed, state, led
  );
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stability counter; emits one pulse per accepted press.
module button_debouncer
  import pong_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic button,
  output logic press
);

  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          settle;

  // The synchronised level has differed from the accepted one long enough.
  assign settle = (sync_q[1] != level_q) && (cnt_q == CNT_LAST);

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], button};
      press  <= settle && sync_q[1];
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (settle) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl_fsm.sv
// Game sequencing: serve, play, miss pause and game over, with BCD scoring.
module pong_game_ctrl_fsm
  import pong_pkg::*;
#(
  parameter int START_LIVES = DEF_START_LIVES,
  parameter int MISS_FRAMES = DEF_MISS_FRAMES
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic              press,
  pong_game_ctrl_if.slave   bus
);

  localparam int            FW         = $clog2(MISS_FRAMES + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(MISS_FRAMES - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(START_LIVES);

  state_t        state_q, state_d;
  score_t        score_q, score_d;
  logic [1:0]    lives_q, lives_d;
  logic [1:0]    speed_q, speed_d;
  logic          led_q, led_d;
  logic          rst_pulse_q, rst_pulse_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      score_q     <= '0;
      lives_q     <= '0;
      speed_q     <= '0;
      led_q       <= 1'b0;
      rst_pulse_q <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      speed_q     <= speed_d;
      led_q       <= led_d;
      rst_pulse_q <= rst_pulse_d;
      fcnt_q      <= fcnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    lives_d     = lives_q;
    fcnt_d      = fcnt_q;
    rst_pulse_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (press) begin
          score_d     = '0;
          lives_d     = LIVES_INIT;
          rst_pulse_d = 1'b1;
          state_d     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (press) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // A simultaneous hit is discarded: the ball is already past the paddle.
        if (bus.miss) begin
          lives_d = lives_q - 2'd1;
          if (lives_q == 2'd1) begin
            state_d = ST_GAME_OVER;
          end else begin
            fcnt_d  = '0;
            state_d = ST_MISS_WAIT;
          end
        end else if (bus.hit) begin
          score_d = bcd_inc(score_q);
        end
      end
      ST_MISS_WAIT: begin
        if (bus.frame_tick) begin
          if (fcnt_q == FRAME_LAST) begin
            fcnt_d      = '0;
            rst_pulse_d = 1'b1;
            state_d     = ST_SERVE;
          end else begin
            fcnt_d = fcnt_q + FW'(1);
          end
        end
      end
      ST_GAME_OVER: begin
        if (press) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    speed_d = speed_of(score_d.tens);
    led_d   = (state_d == ST_GAME_OVER);
  end

  assign bus.ball_run   = (state_q == ST_PLAY);
  assign bus.ball_reset = rst_pulse_q;
  assign bus.score      = score_q;
  assign bus.lives      = lives_q;
  assign bus.speed      = speed_q;
  assign bus.state      = state_q;
  assign bus.led        = led_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Top level: button debouncer feeding the game sequencer over the controller bundle.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int START_LIVES = DEF_START_LIVES,
  parameter int MISS_FRAMES = DEF_MISS_FRAMES
) (
  input  logic       clk50,
  input  logic       rst_n,
  input  logic       button,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic       miss,
  output logic       ball_run,
  output logic       ball_reset,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [1:0] speed,
  output logic [2:0] state,
  output logic       led
);

  logic press;

  pong_game_ctrl_if bus ();

  assign bus.frame_tick = frame_tick;
  assign bus.hit        = hit;
  assign bus.miss       = miss;

  assign ball_run   = bus.ball_run;
  assign ball_reset = bus.ball_reset;
  assign score      = bus.score;
  assign lives      = bus.lives;
  assign speed      = bus.speed;
  assign state      = bus.state;
  assign led        = bus.led;

  button_debouncer #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debouncer (
    .clk50  (clk50),
    .rst_n  (rst_n),
    .button (button),
    .press  (press)
  );

  pong_game_ctrl_fsm #(
    .START_LIVES (START_LIVES),
    .MISS_FRAMES (MISS_FRAMES)
  ) u_fsm (
    .clk50 (clk50),
    .rst_n (rst_n),
    .press (press),
    .bus   (bus)
  );

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: a decimal game model predicts every output change.
module tb_pong_game_ctrl;

  localparam int DEB    = 4;
  localparam int LIVES  = 3;
  localparam int FRAMES = 3;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_WAIT = 3, S_OVER = 4;

  logic clk50  = 1'b0;
  logic rst_n  = 1'b0;
  logic button = 1'b0;

  pong_game_ctrl_if bus ();

  always #5 clk50 = ~clk50;

  pong_game_ctrl #(
    .DEB_CYCLES  (DEB),
    .START_LIVES (LIVES),
    .MISS_FRAMES (FRAMES)
  ) dut (
    .clk50      (clk50),
    .rst_n      (rst_n),
    .button     (button),
    .frame_tick (bus.frame_tick),
    .hit        (bus.hit),
    .miss       (bus.miss),
    .ball_run   (bus.ball_run),
    .ball_reset (bus.ball_reset),
    .score      (bus.score),
    .lives      (bus.lives),
    .speed      (bus.speed),
    .state      (bus.state),
    .led        (bus.led)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] sc;
    logic [1:0] lv;
    logic [1:0] sp;
    logic       led;
    logic       run;
    logic       rb;
  } snap_t;

  snap_t exp_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  // Game model: score kept as a plain decimal number.
  int m_state = S_IDLE;
  int m_score = 0;
  int m_lives = 0;
  int m_fcnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic snap_t model_snap(input bit rb);
    snap_t s;
    int    tens;
    tens  = m_score / 10;
    s.st  = 3'(m_state);
    s.sc  = {4'(tens), 4'(m_score % 10)};
    s.lv  = 2'(m_lives);
    s.sp  = 2'((tens > 3) ? 3 : tens);
    s.led = (m_state == S_OVER);
    s.run = (m_state == S_PLAY);
    s.rb  = rb;
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.st  = bus.state;
    s.sc  = bus.score;
    s.lv  = bus.lives;
    s.sp  = bus.speed;
    s.led = bus.led;
    s.run = bus.ball_run;
    s.rb  = bus.ball_reset;
    return s;
  endfunction

  task automatic model_press();
    case (m_state)
      S_IDLE: begin
        m_score = 0;
        m_lives = LIVES;
        m_state = S_SERVE;
        exp_q.push_back(model_snap(1'b1));
        exp_q.push_back(model_snap(1'b0));
      end
      S_SERVE: begin
        m_state = S_PLAY;
        exp_q.push_back(model_snap(1'b0));
      end
      S_OVER: begin
        m_state = S_IDLE;
        exp_q.push_back(model_snap(1'b0));
      end
      default: ;
    endcase
  endtask

  task automatic model_pulse(input bit h, input bit m, input bit f);
    if (m_state == S_PLAY) begin
      if (m) begin
        if (m_lives == 1) begin
          m_lives = 0;
          m_state = S_OVER;
        end else begin
          m_lives = m_lives - 1;
          m_state = S_WAIT;
          m_fcnt  = 0;
        end
        exp_q.push_back(model_snap(1'b0));
      end else if (h && m_score < 99) begin
        m_score = m_score + 1;
        exp_q.push_back(model_snap(1'b0));
      end
    end else if (m_state == S_WAIT && f) begin
      m_fcnt = m_fcnt + 1;
      if (m_fcnt == FRAMES) begin
        m_state = S_SERVE;
        exp_q.push_back(model_snap(1'b1));
        exp_q.push_back(model_snap(1'b0));
      end
    end
  endtask

  // Stimulus tasks all start and end at 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic pulse(input bit h, input bit m, input bit f);
    model_pulse(h, m, f);
    bus.hit        = h;
    bus.miss       = m;
    bus.frame_tick = f;
    @(posedge clk50);
    #1;
    bus.hit        = 1'b0;
    bus.miss       = 1'b0;
    bus.frame_tick = 1'b0;
  endtask

  task automatic press_button();
    model_press();
    button = 1'b1;
    idle(10);
    button = 1'b0;
    idle(14);
  endtask

  // Monitor: any change in the observed outputs must match the next expected snapshot.
  bit    mon_en = 1'b0;
  snap_t prev;
  snap_t cur;
  snap_t want;

  always @(negedge clk50) begin
    if (mon_en) begin
      cur = dut_snap();
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%0h, want no change from 0x%0h", cur, prev);
        end else begin
          want = exp_q.pop_front();
          check("scoreboard", 32'(cur), 32'(want));
        end
        prev = cur;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.hit        = 1'b0;
    bus.miss       = 1'b0;
    bus.frame_tick = 1'b0;
    rst_n          = 1'b0;
    #12;
    check("rst_state", bus.state, 0);
    check("rst_score", bus.score, 0);
    check("rst_lives", bus.lives, 0);
    check("rst_speed", bus.speed, 0);
    check("rst_led", bus.led, 0);
    check("rst_ball_run", bus.ball_run, 0);
    check("rst_ball_reset", bus.ball_reset, 0);
    rst_n = 1'b1;
    idle(1);
    prev   = dut_snap();
    mon_en = 1'b1;

    // Short glitches must never be accepted as a press.
    for (int i = 0; i < 50; i++) begin
      button = (i % 3 == 0);
      idle(1);
    end
    button = 1'b0;
    idle(10);
    check("glitch_state", bus.state, S_IDLE);

    press_button();
    check("serve_state", bus.state, S_SERVE);
    check("serve_lives", bus.lives, LIVES);

    press_button();
    check("play_run", bus.ball_run, 1);
    for (int i = 0; i < 9; i++) pulse(1'b1, 1'b0, 1'b0);
    check("score_09", bus.score, 8'h09);
    pulse(1'b1, 1'b0, 1'b0);
    check("score_carry", bus.score, 8'h10);
    for (int i = 0; i < 9; i++) pulse(1'b1, 1'b0, 1'b0);
    check("score_19", bus.score, 8'h19);
    check("speed_1", bus.speed, 1);

    pulse(1'b1, 1'b1, 1'b0);
    check("hitmiss_lives", bus.lives, 2);
    check("hitmiss_score", bus.score, 8'h19);
    check("hitmiss_state", bus.state, S_WAIT);
    for (int i = 0; i < FRAMES; i++) begin
      idle(2);
      pulse(1'b0, 1'b0, 1'b1);
    end
    check("wait_ball_reset", bus.ball_reset, 1);
    check("wait_state", bus.state, S_SERVE);

    press_button();
    for (int i = 0; i < 80; i++) pulse(1'b1, 1'b0, 1'b0);
    check("score_99", bus.score, 8'h99);
    pulse(1'b1, 1'b0, 1'b0);
    check("score_sat", bus.score, 8'h99);
    check("speed_3", bus.speed, 3);

    pulse(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < FRAMES; i++) pulse(1'b0, 1'b0, 1'b1);
    press_button();
    pulse(1'b0, 1'b1, 1'b0);
    check("over_state", bus.state, S_OVER);
    check("over_led", bus.led, 1);
    check("over_score", bus.score, 8'h99);
    press_button();
    check("idle_state", bus.state, S_IDLE);
    check("idle_led", bus.led, 0);

    // Randomised play, including inputs that must be ignored outside PLAY / MISS_WAIT.
    for (int i = 0; i < 300; i++) begin
      if (m_state == S_PLAY || m_state == S_WAIT) begin
        pulse(($urandom_range(1) == 1), ($urandom_range(15) == 0), ($urandom_range(2) == 0));
      end else if ($urandom_range(1) == 1) begin
        pulse(1'b1, ($urandom_range(1) == 1), ($urandom_range(1) == 1));
      end else begin
        press_button();
      end
    end

    // Reach PLAY, then reset between clock edges.
    for (int i = 0; i < 20 && m_state != S_PLAY; i++) begin
      if (m_state == S_WAIT) pulse(1'b0, 1'b0, 1'b1);
      else press_button();
    end
    check("pre_reset_run", bus.ball_run, 1);
    idle(5);
    #2;
    m_state = S_IDLE;
    m_score = 0;
    m_lives = 0;
    exp_q.push_back(model_snap(1'b0));
    rst_n = 1'b0;
    #1;
    check("async_state", bus.state, 0);
    check("async_score", bus.score, 0);
    check("async_lives", bus.lives, 0);
    check("async_speed", bus.speed, 0);
    check("async_led", bus.led, 0);
    check("async_ball_run", bus.ball_run, 0);
    check("async_ball_reset", bus.ball_reset, 0);
    idle(3);
    rst_n = 1'b1;
    idle(20);
    check("post_reset_idle", bus.state, S_IDLE);
    press_button();
    check("post_reset_serve", bus.state, S_SERVE);

    idle(10);
    check("queue_empty", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
